// File: rtl/sram_data_controller_pkg.sv
// Shared types and helpers for the SRAM-backed memory controllers.
// Used by the data controller now and by the instruction fetch controller later.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_t;

  localparam logic [31:0] DEFAULT_DATA_BASE = 32'd1024;
  localparam int HALF_W = 16;

  // Byte address to 32-bit word index, wrapping modulo 2^32 below the base.
  function automatic logic [31:0] word_index(input logic [31:0] address,
                                             input logic [31:0] base);
    return (address - base) >> 2;
  endfunction

endpackage

// File: rtl/sram_data_controller_if.sv
// MEM-stage request bus between the pipeline (master) and the SRAM data controller (slave).
interface sram_data_controller_if;

  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (
    output rd_en, wr_en, address, wdata,
    input  rdata, ready
  );

  modport slave (
    input  rd_en, wr_en, address, wdata,
    output rdata, ready
  );

endinterface

// File: rtl/sram_data_controller_wait_counter.sv
// Wait-state counter for halfword SRAM cycles.
// Flags the cycle on which the count reaches WAIT_CYCLES.
module mem_wait_counter #(
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [3:0] TERM = 4'(WAIT_CYCLES);

  logic [3:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 4'd1;
    end
  end

  assign terminal = (count == TERM);

endmodule

// File: rtl/sram_data_controller.sv
// Splits 32-bit MEM-stage loads/stores into two wait-stated 16-bit SRAM cycles.
// Optional SRAM_ADDR_CHECK_EN adds addr_err and rejects unaligned or below-base addresses.
module sram_data_controller
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] DATA_BASE   = DEFAULT_DATA_BASE,
  parameter int          SRAM_ADDR_W = 18,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sram_data_controller_if.slave  bus,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [HALF_W-1:0]      sram_dout,
  input  logic [HALF_W-1:0]      sram_din,
  output logic                   sram_we_n
`ifdef SRAM_ADDR_CHECK_EN
  ,
  output logic                   addr_err
`endif
);

  localparam int IDX_W = SRAM_ADDR_W - 1;

  state_t            state;
  logic              is_write;
  logic              hi_setup;
  logic [IDX_W-1:0]  idx_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [IDX_W-1:0]  idx_now;
  logic              request;
  logic              reject;
  logic              cnt_clear;
  logic              cnt_enable;
  logic              cnt_done;

  assign request = bus.rd_en | bus.wr_en;
  assign idx_now = IDX_W'(word_index(bus.address, DATA_BASE));

`ifdef SRAM_ADDR_CHECK_EN
  assign reject = (bus.address < DATA_BASE) || (bus.address[1:0] != 2'b00);
`else
  assign reject = 1'b0;
`endif

  // The write setup cycle at the start of HI must not consume a wait state.
  assign cnt_clear  = (state == IDLE) || (((state == LO) || (state == HI)) && cnt_done);
  assign cnt_enable = (state == LO) || ((state == HI) && !hi_setup);

  mem_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .terminal (cnt_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      is_write  <= 1'b0;
      hi_setup  <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      sram_addr <= '0;
      sram_dout <= '0;
      sram_we_n <= 1'b1;
`ifdef SRAM_ADDR_CHECK_EN
      addr_err  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (request && reject) begin
            state <= DONE;
`ifdef SRAM_ADDR_CHECK_EN
            addr_err <= 1'b1;
`endif
          end else if (request) begin
            is_write  <= bus.wr_en;
            idx_q     <= idx_now;
            wdata_q   <= bus.wdata;
            sram_addr <= {idx_now, 1'b0};
            sram_dout <= bus.wdata[15:0];
            sram_we_n <= ~bus.wr_en;
            state     <= LO;
          end
        end
        LO: begin
          if (cnt_done) begin
            if (!is_write) begin
              rdata_q[15:0] <= sram_din;
            end
            sram_addr <= {idx_q, 1'b1};
            sram_dout <= wdata_q[31:16];
            sram_we_n <= 1'b1;
            hi_setup  <= is_write;
            state     <= HI;
          end
        end
        HI: begin
          // A write holds we_n high for one cycle so the new address settles first.
          if (hi_setup) begin
            hi_setup  <= 1'b0;
            sram_we_n <= 1'b0;
          end else if (cnt_done) begin
            if (!is_write) begin
              rdata_q[31:16] <= sram_din;
            end
            sram_we_n <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
`ifdef SRAM_ADDR_CHECK_EN
          addr_err <= 1'b0;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = (state == IDLE) ? ~request : (state == DONE);

endmodule

// File: tb/tb_sram_data_controller.sv
// Directed and randomized checks of sram_data_controller against a word-level memory model.
// Builds with or without SRAM_ADDR_CHECK_EN.
module tb_sram_data_controller;

  localparam int          WAIT = 3;
  localparam int          AW   = 18;
  localparam logic [31:0] BASE = 32'd1024;
  localparam int          NW   = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [AW-1:0]   sram_addr;
  logic [15:0]     sram_dout;
  logic [15:0]     sram_din;
  logic            sram_we_n;
`ifdef SRAM_ADDR_CHECK_EN
  logic            addr_err;
`endif

  sram_data_controller_if bus ();

  sram_data_controller #(
    .DATA_BASE   (BASE),
    .SRAM_ADDR_W (AW),
    .WAIT_CYCLES (WAIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .sram_addr (sram_addr),
    .sram_dout (sram_dout),
    .sram_din  (sram_din),
    .sram_we_n (sram_we_n)
`ifdef SRAM_ADDR_CHECK_EN
    ,
    .addr_err  (addr_err)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural SRAM device: asynchronous read, write while we_n is low at a clock edge.
  logic [15:0] sram_mem [0:(1<<AW)-1];
  assign sram_din = sram_mem[sram_addr];
  always @(posedge clk) begin
    if (!sram_we_n) sram_mem[sram_addr] <= sram_dout;
  end

  // Each falling edge of we_n logs the address and data presented with it.
  int          we_falls = 0;
  logic        prev_we  = 1'b1;
  logic [33:0] we_log[$];
  always @(negedge clk) begin
    if (prev_we && !sram_we_n) begin
      we_falls++;
      we_log.push_back({sram_addr, sram_dout});
    end
    prev_we = sram_we_n;
  end

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_mem [0:NW-1];
  logic [31:0] exp_rdata;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int exp_latency(input logic is_wr);
    return 2 * (WAIT + 1) + 1 + (is_wr ? 1 : 0);
  endfunction

  function automatic logic [AW-1:0] lo_half_addr(input logic [31:0] addr);
    logic [31:0] idx;
    idx = ((addr - BASE) / 4) % (32'd1 << (AW - 1));
    return AW'(idx * 2);
  endfunction

  task automatic wait_ready(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.ready) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic apply_stimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] data, input logic hold, output int lat);
    @(posedge clk);
    @(negedge clk);
    bus.rd_en   = rd;
    bus.wr_en   = wr;
    bus.address = addr;
    bus.wdata   = data;
    wait_ready(lat);
    if (!hold) begin
      bus.rd_en = 1'b0;
      bus.wr_en = 1'b0;
    end
  endtask

  initial begin
    int          lat;
    int          f0;
    int          q0;
    logic        rd;
    logic        wr;
    int          idx;
    logic [31:0] data;
    logic [AW-1:0] ha;

    bus.rd_en   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.address = '0;
    bus.wdata   = '0;
    exp_rdata   = '0;

    // Reset and idle.
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_ready", 32'(bus.ready), 32'd1);
    check_output("rst_we_n", 32'(sram_we_n), 32'd1);
    check_output("rst_rdata", bus.rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("idle_ready", 32'(bus.ready), 32'd1);
    check_output("idle_addr", 32'(sram_addr), 32'd0);

    // Write 0xDEADBEEF to 1028: halfwords 2 and 3.
    f0 = we_falls;
    q0 = we_log.size();
    apply_stimulus(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0, lat);
    check_output("wr_latency", 32'(lat), 32'(exp_latency(1'b1)));
    check_output("wr_pulses", 32'(we_falls - f0), 32'd2);
    check_output("wr_lo_addr", 32'(we_log[q0][33:16]), 32'd2);
    check_output("wr_lo_data", 32'(we_log[q0][15:0]), 32'h0000BEEF);
    check_output("wr_hi_addr", 32'(we_log[q0+1][33:16]), 32'd3);
    check_output("wr_hi_data", 32'(we_log[q0+1][15:0]), 32'h0000DEAD);
    check_output("wr_rdata_hold", bus.rdata, exp_rdata);
    exp_mem[1] = 32'hDEADBEEF;

    // Read it back, held through DONE so a second access follows immediately.
    f0 = we_falls;
    apply_stimulus(1'b1, 1'b0, 32'd1028, 32'h0, 1'b1, lat);
    exp_rdata = exp_mem[1];
    check_output("rd_latency", 32'(lat), 32'(exp_latency(1'b0)));
    check_output("rd_data", bus.rdata, exp_rdata);
    @(posedge clk);
    #1;
    check_output("b2b_ready_one_cycle", 32'(bus.ready), 32'd0);
    wait_ready(lat);
    bus.rd_en = 1'b0;
    check_output("b2b_latency", 32'(lat), 32'(exp_latency(1'b0)));
    check_output("b2b_rdata", bus.rdata, exp_rdata);
    check_output("rd_no_strobe", 32'(we_falls - f0), 32'd0);

    // rd_en and wr_en together behave as a write.
    apply_stimulus(1'b1, 1'b1, 32'd1032, 32'h12345678, 1'b0, lat);
    exp_mem[2] = 32'h12345678;
    check_output("both_latency", 32'(lat), 32'(exp_latency(1'b1)));
    check_output("both_rdata_kept", bus.rdata, exp_rdata);
    check_output("both_sram", {sram_mem[5], sram_mem[4]}, 32'h12345678);

    // Reset asserted during HI of a read.
    @(posedge clk);
    @(negedge clk);
    bus.rd_en   = 1'b1;
    bus.address = 32'd1028;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    bus.rd_en = 1'b0;
    #1;
    exp_rdata = '0;
    check_output("rst_hi_we_n", 32'(sram_we_n), 32'd1);
    check_output("rst_hi_rdata", bus.rdata, exp_rdata);
    check_output("rst_hi_ready", 32'(bus.ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, lat);
    exp_rdata = exp_mem[1];
    check_output("post_rst_latency", 32'(lat), 32'(exp_latency(1'b0)));
    check_output("post_rst_rdata", bus.rdata, exp_rdata);

    // Reset during LO of a write releases we_n immediately.
    @(posedge clk);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.address = 32'd1036;
    bus.wdata   = 32'hCAFEF00D;
    repeat (2) @(posedge clk);
    #1;
    check_output("lo_we_low", 32'(sram_we_n), 32'd0);
    rst_n = 1'b0;
    #1;
    check_output("rst_async_we_n", 32'(sram_we_n), 32'd1);
    bus.wr_en = 1'b0;
    exp_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;

`ifdef SRAM_ADDR_CHECK_EN
    // Rejected addresses go straight to DONE with no SRAM activity.
    f0 = we_falls;
    apply_stimulus(1'b1, 1'b0, 32'd1000, 32'h0, 1'b0, lat);
    check_output("err_low_latency", 32'(lat), 32'd1);
    check_output("err_low_flag", 32'(addr_err), 32'd1);
    check_output("err_low_rdata", bus.rdata, exp_rdata);
    apply_stimulus(1'b0, 1'b1, 32'd1030, 32'h55AA55AA, 1'b0, lat);
    check_output("err_align_flag", 32'(addr_err), 32'd1);
    check_output("err_no_strobe", 32'(we_falls - f0), 32'd0);
    @(posedge clk);
    #1;
    check_output("err_flag_clears", 32'(addr_err), 32'd0);
`else
    // Below-base addresses wrap to the top of the SRAM.
    apply_stimulus(1'b0, 1'b1, 32'd1020, 32'hA5A55A5A, 1'b0, lat);
    ha = lo_half_addr(32'd1020);
    check_output("wrap_addr", 32'(ha), 32'h0003FFFE);
    check_output("wrap_sram", {sram_mem[ha + 1'b1], sram_mem[ha]}, 32'hA5A55A5A);
    apply_stimulus(1'b1, 1'b0, 32'd1020, 32'h0, 1'b0, lat);
    exp_rdata = 32'hA5A55A5A;
    check_output("wrap_rdata", bus.rdata, exp_rdata);
`endif

    // Fill the model region, then random mixed traffic.
    for (int i = 0; i < NW; i++) begin
      data = $urandom;
      apply_stimulus(1'($urandom_range(0, 1)), 1'b1, BASE + 32'(4 * i), data, 1'b0, lat);
      exp_mem[i] = data;
      check_output("fill_sram", {sram_mem[2*i+1], sram_mem[2*i]}, exp_mem[i]);
    end
    for (int n = 0; n < 40; n++) begin
      idx  = int'($urandom_range(0, NW - 1));
      data = $urandom;
      wr   = 1'($urandom_range(0, 1));
      rd   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      f0   = we_falls;
      apply_stimulus(rd, wr, BASE + 32'(4 * idx), data, 1'b0, lat);
      if (wr) begin
        exp_mem[idx] = data;
      end else begin
        exp_rdata = exp_mem[idx];
      end
      check_output("rand_latency", 32'(lat), 32'(exp_latency(wr)));
      check_output("rand_rdata", bus.rdata, exp_rdata);
      check_output("rand_pulses", 32'(we_falls - f0), wr ? 32'd2 : 32'd0);
      check_output("rand_sram", {sram_mem[2*idx+1], sram_mem[2*idx]}, exp_mem[idx]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
